// File: rtl/led_status_pkg.sv
// Shared definitions for the LED status controller: channel mode encoding
// and a width helper used to size counters and the channel select.
package led_status_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } led_mode_e;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int min1_clog2(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/led_timebase.sv
// Shared timebase: prescaler tick, free-running PWM counter and the
// blink phase that every channel follows.
module led_timebase
    import led_status_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 1000,
    parameter int BLINK_TICKS = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                tick_o,
    output logic                wrap_o,
    output logic [PWM_BITS-1:0] pwm_cnt_o,
    output logic                phase_o
);

    localparam int PS_W = min1_clog2(PRESCALE);
    localparam int BT_W = min1_clog2(BLINK_TICKS);

    logic [PS_W-1:0]     ps_q, ps_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [BT_W-1:0]     bl_q, bl_d;
    logic                phase_q, phase_d;
    logic                tick;

    always_comb begin
        tick    = (ps_q == PS_W'(PRESCALE - 1));
        ps_d    = tick ? '0 : ps_q + 1'b1;
        pwm_d   = pwm_q;
        bl_d    = bl_q;
        phase_d = phase_q;
        if (tick) begin
            pwm_d = pwm_q + 1'b1;
            if (bl_q == BT_W'(BLINK_TICKS - 1)) begin
                bl_d    = '0;
                phase_d = ~phase_q;
            end else begin
                bl_d = bl_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ps_q    <= '0;
            pwm_q   <= '0;
            bl_q    <= '0;
            phase_q <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            pwm_q   <= pwm_d;
            bl_q    <= bl_d;
            phase_q <= phase_d;
        end
    end

    // wrap_o marks the edge where the PWM counter rolls over to zero.
    assign tick_o    = tick;
    assign wrap_o    = tick && (pwm_q == '1);
    assign pwm_cnt_o = pwm_q;
    assign phase_o   = phase_q;

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel LED controller: per-channel OFF/ON/BLINK/PWM modes driven
// from one shared timebase, with period-aligned PWM duty updates.
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 1000,
    parameter int BLINK_TICKS = 256,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                                         CLK_IN,
    input  logic                                         RST,
    input  logic                                         CFG_WE,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   CFG_CH,
    input  logic [1:0]                                   CFG_MODE,
    input  logic [PWM_BITS-1:0]                          CFG_DUTY,
    output logic                                         CFG_ERR,
    output logic [N_CH-1:0]                              LED
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                tick;
    logic                wrap;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                phase;
    logic                cfg_valid;
    logic [N_CH-1:0]     level_d, level_q;
    logic [N_CH-1:0]     led_q;
    logic                err_q;

    led_timebase #(
        .PWM_BITS    (PWM_BITS),
        .PRESCALE    (PRESCALE),
        .BLINK_TICKS (BLINK_TICKS)
    ) u_timebase (
        .clk_i     (CLK_IN),
        .rst_i     (RST),
        .tick_o    (tick),
        .wrap_o    (wrap),
        .pwm_cnt_o (pwm_cnt),
        .phase_o   (phase)
    );

    assign cfg_valid = (32'(CFG_CH) < 32'(N_CH));

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        led_mode_e           mode_q;
        logic [PWM_BITS-1:0] pend_q;
        logic [PWM_BITS-1:0] act_q;
        logic                ch_we;
        logic                ch_level;

        assign ch_we = CFG_WE && cfg_valid && (CFG_CH == CH_W'(g));

        // Non-PWM writes load the active duty at once; PWM writes wait for
        // the counter rollover so a running period is never cut short.
        always_ff @(posedge CLK_IN) begin
            if (RST) begin
                mode_q <= MODE_OFF;
                pend_q <= '0;
                act_q  <= '0;
            end else begin
                if (ch_we) begin
                    mode_q <= led_mode_e'(CFG_MODE);
                    pend_q <= CFG_DUTY;
                end
                if (ch_we && (CFG_MODE != MODE_PWM)) begin
                    act_q <= CFG_DUTY;
                end else if (wrap) begin
                    act_q <= ch_we ? CFG_DUTY : pend_q;
                end
            end
        end

        always_comb begin
            ch_level = 1'b0;
            case (mode_q)
                MODE_OFF:   ch_level = 1'b0;
                MODE_ON:    ch_level = 1'b1;
                MODE_BLINK: ch_level = phase;
                MODE_PWM:   ch_level = (pwm_cnt < act_q);
                default:    ch_level = 1'b0;
            endcase
        end

        assign level_d[g] = ch_level;
    end

    // Two register stages: level sample, then polarity-adjusted drive.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            level_q <= '0;
            led_q   <= {N_CH{ACTIVE_LOW}};
            err_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= level_q ^ {N_CH{ACTIVE_LOW}};
            err_q   <= CFG_WE && !cfg_valid;
        end
    end

    assign LED     = led_q;
    assign CFG_ERR = err_q;

    logic unused_tick;
    assign unused_tick = tick;

endmodule

// File: doc/led_status_ctrl.md
LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of LED channels, range 1..16.
REQ-002 SHALL have parameter PWM_BITS, default 8: PWM counter and duty width, range 2..12.
REQ-003 SHALL have parameter PRESCALE, default 1000: CLK_IN cycles per timebase tick, range 1..65535.
REQ-004 SHALL have parameter BLINK_TICKS, default 256: ticks per blink half-period, range 1..65535.
REQ-005 SHALL have parameter ACTIVE_LOW, default 0: 1 inverts every LED output.
REQ-006 SHALL have port CLK_IN, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port CFG_WE, input, 1 bit: configuration write strobe, one write per high cycle.
REQ-009 SHALL have port CFG_CH, input, $clog2(N_CH) bits (min 1): target channel.
REQ-010 SHALL have port CFG_MODE, input, 2 bits: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
REQ-011 SHALL have port CFG_DUTY, input, PWM_BITS bits: PWM duty value.
REQ-012 SHALL have port CFG_ERR, output, 1 bit: one-cycle pulse on a write to CFG_CH >= N_CH.
REQ-013 SHALL have port LED, output, N_CH bits: registered LED drive.

Function
REQ-014 SHALL count a prescaler 0..PRESCALE-1 and assert internal tick for one cycle when it equals PRESCALE-1; PRESCALE=1 gives tick every cycle.
REQ-015 SHALL advance a free-running PWM_BITS counter on each tick, wrapping 2^PWM_BITS-1 -> 0.
REQ-016 SHALL toggle a shared blink phase on the tick where the blink counter equals BLINK_TICKS-1, then reset that counter to 0; phase is 0 after reset.
REQ-017 SHALL, on CFG_WE with a valid CFG_CH, load that channel's mode and pending duty at the same edge; other channels are unchanged.
REQ-018 SHALL ignore writes with CFG_CH >= N_CH, changing no state, and pulse CFG_ERR high in the next cycle.
REQ-019 SHALL copy pending duty to active duty on the tick where the PWM counter wraps to 0, or immediately at the write edge if the written mode is not PWM. Duty updates are glitch-free at PWM period boundaries.
REQ-020 SHALL compute the per-channel level as OFF=0, ON=1, BLINK=blink phase, PWM=(PWM counter < active duty).
REQ-021 SHALL register LED = level XOR ACTIVE_LOW, so a config write is visible on LED at the second rising edge after the edge that samples CFG_WE.
REQ-022 SHALL keep duty 0 always off in PWM mode, and duty 2^PWM_BITS-1 off for exactly one tick per period.
REQ-023 SHALL let the later of back-to-back writes to the same channel win; a mode change mid-period takes effect with no period alignment.

Reset
REQ-024 SHALL, while RST is high at a rising edge, clear the prescaler, PWM counter, blink counter and blink phase; set all modes to OFF and all duties to 0; drive CFG_ERR to 0 and LED to {N_CH{ACTIVE_LOW}}.
REQ-025 SHALL let RST take priority over a simultaneous CFG_WE, which is discarded.
REQ-026 SHALL abandon any pending duty when reset is asserted mid-period.

Structure
REQ-027 SHALL place the mode encoding (OFF/ON/BLINK/PWM localparams or enum) in shared package led_status_pkg.
REQ-028 SHALL implement the prescaler, PWM counter, blink counter and phase in one sub-module, led_timebase, instanced once and shared by all channels.
REQ-029 SHALL generate per-channel mode/duty registers with a generate loop in the top module.

Verification (N_CH=4, PWM_BITS=4, PRESCALE=2, BLINK_TICKS=8, ACTIVE_LOW=0)
REQ-030 SHALL cover reset: hold RST 3 cycles, then release -> LED=4'b0000 and CFG_ERR=0 throughout; with ACTIVE_LOW=1 -> LED=4'b1111.
REQ-031 SHALL cover ON latency: write ch2 mode ON at edge n -> LED[2]=1 from edge n+2, other bits stay 0.
REQ-032 SHALL cover PWM duty: ch0 PWM duty 4 -> LED[0] high 8 cycles of every 32; duty 0 -> never high; duty 15 -> high 30 of 32.
REQ-033 SHALL cover blink: ch1 BLINK -> LED[1] toggles every 16 cycles, period 32, aligned to the shared phase.
REQ-034 SHALL cover deferred duty: ch0 PWM duty 4, write duty 12 mid-period -> current period keeps 8 high cycles, next period has 24.
REQ-035 SHALL cover errors and collisions: write CFG_CH=5 (width 2 gives CFG_CH=1, so use N_CH=3 and CFG_CH=3) -> CFG_ERR one-cycle pulse, LED unchanged; CFG_WE and RST together -> write dropped.
